// File: rtl/fpnew_slice_out_arbiter.sv
// Round-robin arbiter that merges per-format-slice results into one output stream
// through a 2-entry skid FIFO; supports flush and synchronous reset.
module fpnew_slice_out_arbiter #(
  parameter int NumSlices = 4,
  parameter int Width     = 32,
  parameter int TagWidth  = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumSlices-1:0]            slc_valid_i,
  output logic [NumSlices-1:0]            slc_ready_o,
  input  logic [NumSlices*Width-1:0]      slc_result_i,
  input  logic [NumSlices*5-1:0]          slc_status_i,
  input  logic [NumSlices-1:0]            slc_ext_bit_i,
  input  logic [NumSlices*TagWidth-1:0]   slc_tag_i,
  input  logic                            flush_i,
  output logic [Width-1:0]                result_o,
  output logic [4:0]                      status_o,
  output logic                            extension_bit_o,
  output logic [TagWidth-1:0]             tag_o,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic                            busy_o
);

  localparam int EntW = Width + 5 + 1 + TagWidth;
  localparam int RrW  = (NumSlices > 1) ? $clog2(NumSlices) : 1;

  logic [1:0]           count_q, count_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [RrW-1:0]       rr_q, rr_d;
  logic                 init_q, init_d;
  logic [EntW-1:0]      mem_q [2];
  logic [EntW-1:0]      mem_d [2];

  logic                 head_valid;
  logic                 pop;
  logic                 space;
  logic                 grant_any;
  logic [RrW-1:0]       grant_idx;
  logic [NumSlices-1:0] grant;
  logic [EntW-1:0]      new_entry;
  logic [EntW-1:0]      head;

  // Round-robin search from rr_q; blocked during reset, the cycle after it, and flush.
  always_comb begin
    int             idx;
    logic [RrW-1:0] cand;
    logic           hit;
    idx        = 0;
    cand       = '0;
    hit        = 1'b0;
    grant_any  = 1'b0;
    grant_idx  = '0;
    head_valid = (count_q != 2'd0) && !rst_i;
    pop        = head_valid && out_ready_i;
    space      = (count_q < 2'd2) || pop;
    if (!rst_i && !init_q && !flush_i && space) begin
      for (int i = 0; i < NumSlices; i++) begin
        idx = int'(rr_q) + i;
        idx = (idx >= NumSlices) ? idx - NumSlices : idx;
        cand = RrW'(idx);
        hit = !grant_any && slc_valid_i[cand];
        grant_idx = hit ? cand : grant_idx;
        grant_any = grant_any | hit;
      end
    end else begin
      grant_any = 1'b0;
    end
    grant = grant_any ? (NumSlices'(1) << grant_idx) : '0;
  end

  // Gather the granted slice's fields into one FIFO entry.
  always_comb begin
    new_entry = '0;
    for (int s = 0; s < NumSlices; s++) begin
      if (grant_idx == RrW'(s)) begin
        new_entry = {slc_result_i[s*Width +: Width], slc_status_i[s*5 +: 5],
                     slc_ext_bit_i[s], slc_tag_i[s*TagWidth +: TagWidth]};
      end else begin
        new_entry = new_entry;
      end
    end
  end

  // FIFO and priority-pointer next state.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rr_d     = rr_q;
    init_d   = 1'b0;
    mem_d    = mem_q;
    if (flush_i) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (grant_any) begin
        mem_d[wr_ptr_q] = new_entry;
        wr_ptr_d        = ~wr_ptr_q;
        rr_d            = (grant_idx == RrW'(NumSlices - 1)) ? '0 : grant_idx + RrW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({grant_any, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state; init_q blocks grants for the first cycle out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      rr_q     <= '0;
      init_q   <= 1'b1;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rr_q     <= rr_d;
      init_q   <= init_d;
    end
  end

  // Entry storage carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    mem_q[0] <= mem_d[0];
    mem_q[1] <= mem_d[1];
  end

  // Head outputs are forced to zero whenever nothing is buffered.
  always_comb begin
    head = head_valid ? mem_q[rd_ptr_q] : '0;
    {result_o, status_o, extension_bit_o, tag_o} = head;
  end

  assign slc_ready_o = grant;
  assign out_valid_o = head_valid;
  assign busy_o      = head_valid | (|slc_valid_i);

endmodule

// File: tb/tb_fpnew_slice_out_arbiter.sv
// Randomized bench for fpnew_slice_out_arbiter against a queue-based reference model.
module tb_fpnew_slice_out_arbiter;

  localparam int N = 4;
  localparam int W = 32;
  localparam int T = 1;

  typedef struct {
    logic [W-1:0] res;
    logic [4:0]   st;
    logic         ext;
    logic [T-1:0] tag;
  } ent_t;

  logic           clk;
  logic           rst_i;
  logic [N-1:0]   slc_valid_i;
  logic [N-1:0]   slc_ready_o;
  logic [N*W-1:0] slc_result_i;
  logic [N*5-1:0] slc_status_i;
  logic [N-1:0]   slc_ext_bit_i;
  logic [N*T-1:0] slc_tag_i;
  logic           flush_i;
  logic [W-1:0]   result_o;
  logic [4:0]     status_o;
  logic           extension_bit_o;
  logic [T-1:0]   tag_o;
  logic           out_valid_o;
  logic           out_ready_i;
  logic           busy_o;

  fpnew_slice_out_arbiter #(.NumSlices(N), .Width(W), .TagWidth(T)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .slc_valid_i(slc_valid_i), .slc_ready_o(slc_ready_o),
    .slc_result_i(slc_result_i), .slc_status_i(slc_status_i),
    .slc_ext_bit_i(slc_ext_bit_i), .slc_tag_i(slc_tag_i),
    .flush_i(flush_i),
    .result_o(result_o), .status_o(status_o), .extension_bit_o(extension_bit_o), .tag_o(tag_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  ent_t model_q[$];
  int   model_rr = 0;
  bit   model_cold = 1'b1;
  ent_t slice_data[N];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_data();
    for (int s = 0; s < N; s++) begin
      slice_data[s].res = $urandom;
      slice_data[s].st  = 5'($urandom);
      slice_data[s].ext = 1'($urandom);
      slice_data[s].tag = T'($urandom);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[(model_rr + i) % N]) return (model_rr + i) % N;
    end
    return -1;
  endfunction

  // One clock cycle: drive, check against the model, then advance the model on the edge.
  task automatic step(input logic [N-1:0] v, input logic rdy, input logic fl, input logic rs);
    int           k;
    bit           ov;
    bit           popm;
    logic [N-1:0] exp_rdy;
    ent_t         h;
    @(negedge clk);
    slc_valid_i = v;
    out_ready_i = rdy;
    flush_i     = fl;
    rst_i       = rs;
    for (int s = 0; s < N; s++) begin
      slc_result_i[s*W +: W] = slice_data[s].res;
      slc_status_i[s*5 +: 5] = slice_data[s].st;
      slc_ext_bit_i[s]       = slice_data[s].ext;
      slc_tag_i[s*T +: T]    = slice_data[s].tag;
    end
    #2;
    ov   = (model_q.size() != 0) && !rs;
    popm = ov && rdy;
    k    = -1;
    if (!rs && !model_cold && !fl && (model_q.size() < 2 || popm)) k = pick(v);
    exp_rdy = (k >= 0) ? (N'(1) << k) : '0;
    h = '{res: '0, st: '0, ext: 1'b0, tag: '0};
    if (ov) h = model_q[0];
    check_eq("ready", slc_ready_o, exp_rdy);
    check_eq("out_valid", out_valid_o, ov);
    check_eq("result", result_o, h.res);
    check_eq("status", status_o, h.st);
    check_eq("ext", extension_bit_o, h.ext);
    check_eq("tag", tag_o, h.tag);
    check_eq("busy", busy_o, ov || (|v));
    @(posedge clk);
    if (rs) begin
      model_q.delete();
      model_rr   = 0;
      model_cold = 1'b1;
    end else begin
      model_cold = 1'b0;
      if (fl) begin
        model_q.delete();
      end else begin
        if (popm) void'(model_q.pop_front());
        if (k >= 0) begin
          model_q.push_back(slice_data[k]);
          model_rr = (k + 1) % N;
        end
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; out_ready_i = 1'b0; slc_valid_i = '0;
    slc_result_i = '0; slc_status_i = '0; slc_ext_bit_i = '0; slc_tag_i = '0;
    rand_data();
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    step(4'b1010, 1'b0, 1'b0, 1'b1);
    step(4'b1111, 1'b1, 1'b0, 1'b0);

    // Single result from slice 2
    slice_data[2].res = 32'h3F80_0000;
    slice_data[2].tag = 1'b1;
    step(4'b0100, 1'b1, 1'b0, 1'b0);
    #1;
    check_eq("single_result", result_o, 32'h3F80_0000);
    check_eq("single_tag", tag_o, 1'b1);
    step(4'b0000, 1'b1, 1'b0, 1'b0);

    // Fairness from rr=0
    step(4'b0000, 1'b1, 1'b0, 1'b1);
    step(4'b0000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      rand_data();
      step(4'b1111, 1'b1, 1'b0, 1'b0);
    end

    // Backpressure then release
    for (int i = 0; i < 4; i++) begin
      rand_data();
      step(4'b1111, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 2; i++) step(4'b1111, 1'b1, 1'b0, 1'b0);

    // Flush with a full FIFO
    step(4'b0010, 1'b0, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b0, 1'b0);

    // Reset with one entry buffered
    step(4'b0000, 1'b1, 1'b1, 1'b0);
    step(4'b1000, 1'b1, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b0, 1'b1);
    step(4'b0110, 1'b1, 1'b0, 1'b0);
    step(4'b0110, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 600; i++) begin
      rand_data();
      step(N'($urandom),
           1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 99) < 5),
           1'($urandom_range(0, 99) < 2));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
